// File: rtl/data_chk_axi_mm_burst_if.sv
// AXI4 read-channel bundle (AR + R) between the burst read checker and the interconnect.
// The master modport is the checker side; the slave modport is the memory/interconnect side.
interface data_chk_axi_mm_burst_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [2:0]                m_axi_arprot;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arprot, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arprot, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 INCR burst read checker: reads a region in fixed bursts and compares each beat to the
// writer's incrementing pattern. Define DATA_CHK_FIRST_ERR_CAPTURE_EN to build first-error capture.
module data_chk_axi_mm_burst #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 16,
    parameter int C_AXI_SIZE     = $clog2(AXI_DATA_WIDTH/8)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]               BYTES,
    input  logic [15:0]               REPEAT,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERROR,
    output logic [15:0]               ERR_COUNT,
    output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    output logic [AXI_DATA_WIDTH-1:0] FIRST_ERR_DATA,
    data_chk_axi_mm_burst_if.master   m_axi,
    output logic [2:0]                dbg_state
);
    localparam int BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
    localparam int BURST_BYTES    = MAX_BURST_LEN * BYTES_PER_BEAT;
    localparam int WORDS          = AXI_DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_AR    = 3'd1,
        S_READ_BURST = 3'd2,
        S_NEXT       = 3'd3,
        S_FINISH     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] base_q, addr_q;
    logic [15:0]               bytes_q, repeat_q, pass_q, err_count_q;
    logic [31:0]               beat_idx_q;
    logic [8:0]                burst_beat_q;
    logic [16:0]               bytes_read_q, bytes_sum;
    logic                      error_q, done_q;
    logic                      start_ok, zero_len, r_hs, last_beat, beat_fail, pass_end, last_pass;
    logic [AXI_DATA_WIDTH-1:0] exp_word;

    // AR and R follow AXI valid/ready: a transfer happens on a rising ACLK edge with valid and
    // ready both high; arvalid, once raised, holds with a stable araddr until arready.
    assign start_ok  = (state == S_IDLE) && START;
    assign zero_len  = (BYTES == 16'd0) || (REPEAT == 16'd0);
    assign r_hs      = m_axi.m_axi_rvalid && m_axi.m_axi_rready;
    assign last_beat = (burst_beat_q == 9'(MAX_BURST_LEN - 1));
    assign exp_word  = {WORDS{beat_idx_q}};
    assign beat_fail = r_hs && ((m_axi.m_axi_rresp != 2'b00) || (m_axi.m_axi_rdata != exp_word)
                                || (m_axi.m_axi_rlast != last_beat));
    assign bytes_sum = bytes_read_q + 17'(BURST_BYTES);
    assign pass_end  = (bytes_sum >= {1'b0, bytes_q});
    assign last_pass = (pass_q == repeat_q - 16'd1);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt           = state;
        m_axi.m_axi_arvalid = 1'b0;
        m_axi.m_axi_rready  = 1'b0;
        BUSY                = (state != S_IDLE);
        case (state)
            S_IDLE:       if (START) state_nxt = zero_len ? S_FINISH : S_SEND_AR;
            S_SEND_AR: begin
                m_axi.m_axi_arvalid = 1'b1;
                if (m_axi.m_axi_arready) state_nxt = S_READ_BURST;
            end
            S_READ_BURST: begin
                m_axi.m_axi_rready = 1'b1;
                // The burst ends on beat count alone; a misplaced rlast is only flagged.
                if (r_hs && last_beat) state_nxt = S_NEXT;
            end
            S_NEXT:       state_nxt = (pass_end && last_pass) ? S_FINISH : S_SEND_AR;
            S_FINISH:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            base_q       <= '0;
            addr_q       <= '0;
            bytes_q      <= '0;
            repeat_q     <= '0;
            pass_q       <= '0;
            beat_idx_q   <= '0;
            burst_beat_q <= '0;
            bytes_read_q <= '0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state == S_FINISH);
            if (start_ok) begin
                base_q       <= BASE_ADDR;
                addr_q       <= BASE_ADDR;
                bytes_q      <= BYTES;
                repeat_q     <= REPEAT;
                pass_q       <= '0;
                beat_idx_q   <= '0;
                burst_beat_q <= '0;
                bytes_read_q <= '0;
                error_q      <= 1'b0;
                err_count_q  <= '0;
            end
            if (r_hs) begin
                beat_idx_q   <= beat_idx_q + 32'd1;
                burst_beat_q <= last_beat ? 9'd0 : burst_beat_q + 9'd1;
                if (beat_fail) begin
                    error_q <= 1'b1;
                    if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                end
            end
            if (state == S_NEXT) begin
                if (pass_end) begin
                    pass_q       <= pass_q + 16'd1;
                    bytes_read_q <= '0;
                    addr_q       <= base_q;
                    beat_idx_q   <= '0;
                end else begin
                    bytes_read_q <= bytes_sum;
                    addr_q       <= addr_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                end
            end
        end
    end

`ifdef DATA_CHK_FIRST_ERR_CAPTURE_EN
    localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
    logic                      first_seen_q;
    logic [AXI_ADDR_WIDTH-1:0] first_addr_q;
    logic [AXI_DATA_WIDTH-1:0] first_data_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            first_seen_q <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else if (start_ok) begin
            first_seen_q <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else if (beat_fail && !first_seen_q) begin
            first_seen_q <= 1'b1;
            first_addr_q <= addr_q + (AXI_ADDR_WIDTH'(burst_beat_q) << BEAT_SHIFT);
            first_data_q <= m_axi.m_axi_rdata;
        end
    end

    assign FIRST_ERR_ADDR = first_addr_q;
    assign FIRST_ERR_DATA = first_data_q;
`else
    assign FIRST_ERR_ADDR = '0;
    assign FIRST_ERR_DATA = '0;
`endif

    assign DONE                = done_q;
    assign ERROR               = error_q;
    assign ERR_COUNT           = err_count_q;
    assign dbg_state           = state;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_arprot  = 3'b000;
    assign m_axi.m_axi_arlen   = 8'(MAX_BURST_LEN - 1);
    assign m_axi.m_axi_arsize  = 3'(C_AXI_SIZE);
    assign m_axi.m_axi_arburst = 2'b01;
endmodule

// File: tb/tb_data_chk_axi_mm_burst.sv
// Bench for data_chk_axi_mm_burst: a memory slave preloaded with the writer pattern at 0x1000,
// an expected-AR-address queue, and directed runs with injected faults and backpressure.
module tb_data_chk_axi_mm_burst;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          ACLK;
    logic          ARESET;
    logic [AW-1:0] BASE_ADDR;
    logic [15:0]   BYTES;
    logic [15:0]   REPEAT;
    logic          START;
    logic          BUSY, DONE, ERROR;
    logic [15:0]   ERR_COUNT;
    logic [AW-1:0] FIRST_ERR_ADDR;
    logic [DW-1:0] FIRST_ERR_DATA;
    logic [2:0]    dbg_state;

    data_chk_axi_mm_burst_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) axi();

    data_chk_axi_mm_burst dut (
        .ACLK(ACLK), .ARESET(ARESET), .BASE_ADDR(BASE_ADDR), .BYTES(BYTES), .REPEAT(REPEAT),
        .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT),
        .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .FIRST_ERR_DATA(FIRST_ERR_DATA), .m_axi(axi),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_ar_q[$];
    logic [31:0] mem [0:31];
    int ar_delay, rv_toggle, slverr_en, rlast_bad_en;
    int ar_count, burst_no;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory slave: decisions from values seen at negedge, drives applied just after posedge
    initial begin : slave
        bit          hs_ar, hs_r, av_s, av_prev, r_act, tog;
        logic [31:0] ad_s, ad_prev, r_addr, q;
        int          ar_wait, beat, idx;
        av_prev = 0; r_act = 0; tog = 0; ar_wait = 0; beat = 0; ad_prev = '0; r_addr = '0;
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = 2'b00;
        axi.m_axi_rlast   = 1'b0;
        forever begin
            @(negedge ACLK);
            hs_ar = axi.m_axi_arvalid && axi.m_axi_arready;
            hs_r  = axi.m_axi_rvalid && axi.m_axi_rready;
            av_s  = axi.m_axi_arvalid;
            ad_s  = axi.m_axi_araddr;
            if (!ARESET && av_prev) begin
                check("arvalid_hold", axi.m_axi_arvalid, 1'b1);
                check("araddr_hold", ad_s, ad_prev);
            end
            av_prev = av_s && !hs_ar;
            ad_prev = ad_s;
            @(posedge ACLK);
            #1;
            if (ARESET) begin
                axi.m_axi_arready = 1'b0;
                axi.m_axi_rvalid  = 1'b0;
                axi.m_axi_rlast   = 1'b0;
                r_act = 0; ar_wait = 0; av_prev = 0;
                continue;
            end
            if (hs_ar) begin
                axi.m_axi_arready = 1'b0;
                ar_count++;
                check("ar_expected", exp_ar_q.size() != 0, 1'b1);
                if (exp_ar_q.size() != 0) begin
                    q = exp_ar_q.pop_front();
                    check("ar_addr", ad_s, q);
                end
                check("arlen", axi.m_axi_arlen, 8'd15);
                check("arsize", axi.m_axi_arsize, 3'd2);
                check("arburst", axi.m_axi_arburst, 2'b01);
                check("arprot", axi.m_axi_arprot, 3'b000);
                r_act = 1; beat = 0; r_addr = ad_s; ar_wait = 0;
            end else if (av_s && !axi.m_axi_arready) begin
                if (ar_wait >= ar_delay) axi.m_axi_arready = 1'b1;
                else ar_wait++;
            end
            if (hs_r) begin
                beat++;
                if (beat == 16) begin
                    r_act = 0;
                    burst_no++;
                end
            end
            if (r_act) begin
                tog = !tog;
                axi.m_axi_rvalid = (rv_toggle != 0) ? tog : 1'b1;
                idx = int'((r_addr - 32'h1000) >> 2) + beat;
                axi.m_axi_rdata = mem[idx % 32];
                axi.m_axi_rresp = (slverr_en != 0 && burst_no == 0 && beat == 3) ? 2'b10 : 2'b00;
                axi.m_axi_rlast = (rlast_bad_en != 0 && burst_no == 0) ? (beat == 14) : (beat == 15);
            end else begin
                axi.m_axi_rvalid = 1'b0;
                axi.m_axi_rlast  = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_done"}, DONE, 1'b0);
        check({tag, "_error"}, ERROR, 1'b0);
        check({tag, "_err_count"}, ERR_COUNT, 16'd0);
        check({tag, "_first_addr"}, FIRST_ERR_ADDR, 32'd0);
        check({tag, "_first_data"}, FIRST_ERR_DATA, 32'd0);
        check({tag, "_arvalid"}, axi.m_axi_arvalid, 1'b0);
        check({tag, "_rready"}, axi.m_axi_rready, 1'b0);
        check({tag, "_araddr"}, axi.m_axi_araddr, 32'd0);
        check({tag, "_state"}, dbg_state, 3'd0);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (DONE !== 1'b1 && t < 4000) begin
            @(negedge ACLK);
            t++;
        end
        check({tag, "_done_seen"}, DONE, 1'b1);
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] bytes, input logic [15:0] rep);
        @(negedge ACLK);
        BASE_ADDR = base; BYTES = bytes; REPEAT = rep; START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] base, input logic [15:0] bytes,
                       input logic [15:0] rep, input int exp_cnt, input logic [31:0] fa,
                       input logic [31:0] fd);
        int nb;
        nb = (int'(bytes) + 63) / 64;
        for (int p = 0; p < int'(rep); p++)
            for (int b = 0; b < nb; b++) exp_ar_q.push_back(base + 32'(64 * b));
        burst_no = 0;
        pulse_start(base, bytes, rep);
        check({tag, "_busy"}, BUSY, 1'b1);
        wait_done(tag);
        check({tag, "_error"}, ERROR, (exp_cnt != 0));
        check({tag, "_err_count"}, ERR_COUNT, 16'(exp_cnt));
`ifdef DATA_CHK_FIRST_ERR_CAPTURE_EN
        check({tag, "_first_addr"}, FIRST_ERR_ADDR, fa);
        check({tag, "_first_data"}, FIRST_ERR_DATA, fd);
`else
        check({tag, "_first_addr"}, FIRST_ERR_ADDR, 32'd0);
        check({tag, "_first_data"}, FIRST_ERR_DATA, 32'd0);
`endif
        check({tag, "_ar_left"}, exp_ar_q.size(), 0);
        exp_ar_q.delete();
        @(negedge ACLK);
        check({tag, "_done_pulse"}, DONE, 1'b0);
    endtask

    task automatic zero_len(input string tag, input logic [15:0] bytes, input logic [15:0] rep);
        int a0;
        a0 = ar_count;
        pulse_start(32'h1000, bytes, rep);
        check({tag, "_done_early"}, DONE, 1'b0);
        check({tag, "_busy"}, BUSY, 1'b1);
        @(negedge ACLK);
        check({tag, "_done"}, DONE, 1'b1);
        check({tag, "_idle"}, BUSY, 1'b0);
        check({tag, "_error"}, ERROR, 1'b0);
        check({tag, "_err_count"}, ERR_COUNT, 16'd0);
        @(negedge ACLK);
        check({tag, "_done_pulse"}, DONE, 1'b0);
        check({tag, "_no_ar"}, ar_count, a0);
    endtask

    // directed sequence
    initial begin : stim
        int t, a0, pulses;
        ARESET = 1'b1; START = 1'b0; BASE_ADDR = '0; BYTES = '0; REPEAT = '0;
        ar_delay = 0; rv_toggle = 0; slverr_en = 0; rlast_bad_en = 0; ar_count = 0; burst_no = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i);
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESET = 1'b0;
        @(negedge ACLK);

        run("clean", 32'h1000, 16'd128, 16'd2, 0, 32'd0, 32'd0);

        mem[17] = 32'hDEAD;
        run("corrupt", 32'h1000, 16'd128, 16'd1, 1, 32'h1044, 32'hDEAD);
        mem[17] = 32'd17;

        slverr_en = 1;
        run("slverr", 32'h1000, 16'd128, 16'd1, 1, 32'h100C, 32'd3);
        slverr_en = 0;

        rlast_bad_en = 1;
        run("rlast", 32'h1000, 16'd128, 16'd1, 2, 32'h1038, 32'd14);
        rlast_bad_en = 0;

        zero_len("rep0", 16'd128, 16'd0);
        zero_len("bytes0", 16'd0, 16'd1);

        ar_delay = 5; rv_toggle = 1;
        run("backpressure", 32'h1000, 16'd128, 16'd2, 0, 32'd0, 32'd0);
        ar_delay = 0; rv_toggle = 0;

        run("round_up", 32'h1000, 16'd100, 16'd1, 0, 32'd0, 32'd0);
        run("one_burst", 32'h1000, 16'd64, 16'd2, 0, 32'd0, 32'd0);

        // START while busy must not restart or retarget the run
        exp_ar_q.push_back(32'h1000);
        exp_ar_q.push_back(32'h1040);
        burst_no = 0;
        a0 = ar_count;
        pulse_start(32'h1000, 16'd128, 16'd1);
        t = 0;
        while (ar_count == a0 && t < 200) begin
            @(negedge ACLK);
            t++;
        end
        check("busy_start_first_ar", ar_count > a0, 1'b1);
        pulse_start(32'h2000, 16'd0, 16'd0);
        wait_done("busy_start");
        check("busy_start_err_count", ERR_COUNT, 16'd0);
        check("busy_start_ar_left", exp_ar_q.size(), 0);
        exp_ar_q.delete();
        pulses = 0;
        repeat (10) begin
            @(negedge ACLK);
            if (DONE === 1'b1) pulses++;
        end
        check("busy_start_extra_done", pulses, 0);

        // reset in the middle of a burst
        mem[1] = 32'hBAD;
        exp_ar_q.push_back(32'h1000);
        burst_no = 0;
        pulse_start(32'h1000, 16'd128, 16'd2);
        t = 0;
        while (ERROR !== 1'b1 && t < 200) begin
            @(negedge ACLK);
            t++;
        end
        check("midrst_error_set", ERROR, 1'b1);
        check("midrst_in_burst", dbg_state, 3'd2);
        @(posedge ACLK);
        #3 ARESET = 1'b1;
        @(negedge ACLK);
        check_reset_outputs("midrst");
        @(negedge ACLK);
        ARESET = 1'b0;
        check("midrst_ar_left", exp_ar_q.size(), 0);
        exp_ar_q.delete();
        mem[1] = 32'd1;
        repeat (2) @(negedge ACLK);
        check_reset_outputs("post_rst");

        run("recover", 32'h1000, 16'd128, 16'd1, 0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
